reg_file_param: RTL
===================

Name: reg_file_param

Overview:
Parametrised successor to the pipeline's integer register file. It holds DEPTH = 2**ADDR_WIDTH registers of DATA_WIDTH bits and has NUM_READ combinational read ports and one synchronous write port. It adds a hardwired zero register, optional write-to-read bypass, and a per-register pending-write scoreboard. The scoreboard lets the decode stage detect RAW hazards against instructions still in flight.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register address bits; DEPTH = 2**ADDR_WIDTH
NUM_READ, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET  in  1  asynchronous, active-low reset
WRITE  in  1  write enable
INADDRESS  in  ADDR_WIDTH  write address
IN  in  DATA_WIDTH  write data
OUTADDRESS  in  NUM_READ*ADDR_WIDTH  read addresses; port k = bits [k*ADDR_WIDTH +: ADDR_WIDTH]
OUT  out  NUM_READ*DATA_WIDTH  read data; port k = bits [k*DATA_WIDTH +: DATA_WIDTH]
RESERVE  in  1  mark register RESERVE_ADDRESS as pending-write
RESERVE_ADDRESS  in  ADDR_WIDTH  register being reserved
BUSY  out  NUM_READ  BUSY[k] = pending bit of the register addressed by read port k
BUSY_VEC  out  DEPTH  full pending-bit vector; bit i = register i

Behaviour:
- Reset (RESET=0, asynchronous):
  - All registers are 0 and all pending bits are 0 immediately, without waiting for a clock edge.
  - While reset is held, rising edges are ignored.
  - Outputs: OUT=0 and BUSY=0 for every port; BUSY_VEC=0.
  - Deassertion is sampled on CLK; the first edge with RESET=1 is the first edge that can write.
- Write (edge with WRITE=1):
  - REG[INADDRESS] <= IN.
  - If ZERO_REG=1 and INADDRESS=0, the write is dropped.
- Read:
  - Purely combinational; no clock latency and no delay modelling.
  - OUT port k = REG[addr_k].
  - If ZERO_REG=1 and addr_k=0, OUT port k = 0 regardless of stored contents.
- Bypass (BYPASS=1):
  - When WRITE=1, addr_k = INADDRESS, and the address is not a suppressed zero register, OUT port k = IN in the same cycle.
  - With BYPASS=0, the read returns the old value until the edge.
  - Each port's bypass decision is independent.
- Scoreboard, evaluated at each rising edge:
  - RESERVE=1 sets pending[RESERVE_ADDRESS].
  - WRITE=1 clears pending[INADDRESS].
  - Same address in the same edge: set wins, so the bit stays 1 (a new producer was issued while the older one retired).
  - Different addresses: both updates apply.
  - With ZERO_REG=1, register 0 is never set.
  - A write to a non-pending register is legal and leaves its bit at 0.
  - Re-reserving an already pending register keeps it at 1; there is no counting.
- BUSY output:
  - BUSY[k] = pending[addr_k], combinational.
  - When BYPASS=1 and the same-cycle write targets addr_k with RESERVE not setting that address, BUSY[k] = 0 (data is available now).
- Reset mid-operation: a write or reserve concurrent with RESET=0 has no effect; state stays cleared.
- Address width: all addresses are full-range; there is no out-of-range case.

Test Plan:
1. Reset: write 0xDEADBEEF to r5, pull RESET low between edges -> OUT(r5)=0 immediately and BUSY_VEC=0; edge with WRITE=1, RESET=0 -> r5 stays 0.
2. Write/read: write r3=0x12345678, r31=0xFFFFFFFF; read port0=r3, port1=r31 -> 0x12345678 / 0xFFFFFFFF after the edge. With BYPASS=0, the pre-edge read of r3 = old 0.
3. Bypass: BYPASS=1, r7=0x1; in the same cycle WRITE=1, INADDRESS=7, IN=0xA5A5A5A5, both ports read r7 -> both OUT = 0xA5A5A5A5 before the edge.
4. Zero register: write r0=0xFFFF, RESERVE r0 -> OUT(r0)=0, BUSY_VEC[0]=0. Repeat with ZERO_REG=0 -> OUT(r0)=0x0000FFFF.
5. Scoreboard:
   - RESERVE r9 -> BUSY_VEC[9]=1 and BUSY on a port reading r9.
   - Later edge with WRITE r9 plus RESERVE r9 -> BUSY_VEC[9] stays 1.
   - Next edge with WRITE r9 alone -> BUSY_VEC[9]=0.
   - Edge with WRITE r4 plus RESERVE r6 -> bit4=0, bit6=1.
6. Parameter sweep: DATA_WIDTH=64, ADDR_WIDTH=4, NUM_READ=3 -> write r15=0x0123456789ABCDEF, all three ports read r15 and return the value; BUSY_VEC is 16 bits wide.

Source files
------------

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with zero register, write bypass and pending-write scoreboard
module reg_file_param #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2,
   parameter int ZERO_REG   = 1,
   parameter int BYPASS     = 1
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic                           WRITE,
   input  logic [ADDR_WIDTH-1:0]          INADDRESS,
   input  logic [DATA_WIDTH-1:0]          IN,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] OUTADDRESS,
   output logic [NUM_READ*DATA_WIDTH-1:0] OUT,
   input  logic                           RESERVE,
   input  logic [ADDR_WIDTH-1:0]          RESERVE_ADDRESS,
   output logic [NUM_READ-1:0]            BUSY,
   output logic [(1<<ADDR_WIDTH)-1:0]     BUSY_VEC
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      pending;
   logic [DEPTH-1:0]      pending_next;
   logic                  write_en;
   logic                  reserve_en;

   // Writes and reserves aimed at a hardwired zero register are discarded.
   assign write_en   = WRITE && !((ZERO_REG != 0) && (INADDRESS == '0));
   assign reserve_en = RESERVE && !((ZERO_REG != 0) && (RESERVE_ADDRESS == '0));

   // Register storage: cleared asynchronously, one write per edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (write_en) begin
         regs[INADDRESS] <= IN;
      end
   end

   // Scoreboard next state: retiring write clears first, so a same-address reserve wins.
   always_comb begin
      pending_next = pending;
      if (WRITE) begin
         pending_next[INADDRESS] = 1'b0;
      end
      if (reserve_en) begin
         pending_next[RESERVE_ADDRESS] = 1'b1;
      end
   end

   // Scoreboard state: cleared asynchronously, updated on each edge.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pending <= '0;
      end else begin
         pending <= pending_next;
      end
   end

   assign BUSY_VEC = pending;

   for (genvar k = 0; k < NUM_READ; k++) begin : g_read
      logic [ADDR_WIDTH-1:0] addr;
      logic                  zero_hit;
      logic                  bypass_hit;
      logic                  reserve_hit;

      assign addr        = OUTADDRESS[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign zero_hit    = (ZERO_REG != 0) && (addr == '0);
      assign bypass_hit  = (BYPASS != 0) && WRITE && (addr == INADDRESS) && !zero_hit;
      assign reserve_hit = reserve_en && (RESERVE_ADDRESS == addr);

      // Read data: zero during reset or for the zero register, forwarded write data, else storage.
      always_comb begin
         OUT[k*DATA_WIDTH +: DATA_WIDTH] = regs[addr];
         if (!RESET || zero_hit) begin
            OUT[k*DATA_WIDTH +: DATA_WIDTH] = '0;
         end else if (bypass_hit) begin
            OUT[k*DATA_WIDTH +: DATA_WIDTH] = IN;
         end
      end

      // Hazard flag: a forwarded write makes data available now unless a new producer reserves it.
      always_comb begin
         BUSY[k] = pending[addr];
         if (!RESET || zero_hit) begin
            BUSY[k] = 1'b0;
         end else if (bypass_hit && !reserve_hit) begin
            BUSY[k] = 1'b0;
         end
      end
   end

endmodule
